arduino_pixel_writer: RTL and testbench
=======================================

Name: arduino_pixel_writer

Overview:
- Host-side write port for the 64x48 6-bit framebuffer, written by an Arduino.
- Receives strobed command bytes on the bidirectional IO pins. Decodes cursor, pixel and fill commands.
- Queues pixel writes and commits them to the framebuffer write port only while video is inactive (blanking), so scanout reads are never disturbed.
- It is the writer counterpart to the VGA scanout reader.

Parameters:
- FIFO_DEPTH, 4, pending pixel-write queue depth (power of 2, ≥2).
- FB_W, 64, framebuffer width in pixels.
- FB_H, 48, framebuffer height in pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- strobe_in  in  1  Arduino byte strobe, asynchronous to clk; a byte is taken on its rising edge
- data_in  in  8  command byte; the Arduino holds it stable ≥4 clk after strobe rises
- active  in  1  active-video flag from timing generator
- mem_addr  out  12  framebuffer address, y*FB_W+x
- mem_data  out  6  pixel {r[1:0],g[1:0],b[1:0]}
- mem_we  out  1  framebuffer write enable
- ready  out  1  high when FIFO not full and not filling
- overflow  out  1  sticky: a pixel was dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. All state clears on rst assertion, regardless of the clock.
- Reset values:
  - cursor x = 0, y = 0
  - FIFO empty
  - state IDLE
  - mem_we = 0, mem_addr = 0, mem_data = 0
  - ready = 1, overflow = 0
- Strobe handling: strobe_in passes through a 2-FF synchronizer, then a rising-edge detect.
  - data_in is sampled on the edge-detect cycle, which is the 3rd clk after the strobe rises.
  - Decode completes in that same cycle.
- Opcodes, from data_in[7:6]:
  - 00 PIXEL: push {cursor addr, data_in[5:0]} into the FIFO. Then advance the cursor: x+1. At x = FB_W-1, x = 0 and y+1. At (FB_W-1, FB_H-1), wrap to (0,0).
  - 01 SET_X: x = data_in[5:0].
  - 10 SET_Y: y = data_in[5:0] if < FB_H; otherwise ignored and y is unchanged.
  - 11 FILL: latch the fill colour data_in[5:0] and set fill_pending.
- FIFO overflow: a PIXEL received while the FIFO is full is dropped, and the cursor still advances. overflow sets and stays set until rst.
- State machine:
  - IDLE: drain the FIFO. If fill_pending and the FIFO is empty, go to FILL with fill_addr = 0.
  - FILL: write fill colour to fill_addr, increment on each committed write. After writing address FB_W*FB_H-1 (3071), return to IDLE and clear fill_pending.
- Write commit (combinational gate, registered source):
  - mem_we = ~active & (FILL | FIFO non-empty).
  - mem_addr/mem_data come from the FIFO head in IDLE and from fill_addr/colour in FILL.
  - The FIFO pops and fill_addr advances only in cycles where mem_we = 1.
  - mem_we = 0 in every cycle where active = 1.
- Throughput: one write per blanking cycle.
- ready = ~full & ~fill_pending & state != FILL.
- Commands arriving during FILL:
  - SET_X/SET_Y take effect immediately.
  - PIXEL is queued and drains after the fill.
  - A new FILL updates the colour and restarts fill_addr at 0.
- A PIXEL and a pop in the same cycle on a full FIFO: the push succeeds and there is no overflow.
- Mid-operation reset: the FIFO and the fill are abandoned and mem_we drops immediately.

Test Plan:
- Reset, then SET_X 0x45, SET_Y 0x8A, PIXEL 0x3F with active=0 → one mem_we pulse, addr 10*64+5 = 645, data 0x3F, cursor becomes (6,10).
- Cursor wrap: SET_X 63, SET_Y 47, PIXEL 0x01, then PIXEL 0x02 → writes at addr 3071 then addr 0.
- Hold active=1, send 5 PIXELs with FIFO_DEPTH=4 → ready falls after the 4th, overflow=1, mem_we stays 0. Drop active → exactly 4 writes on consecutive cycles, in order.
- FILL 0xEA (colour 0x2A) with active toggling 50% → exactly 3072 writes covering addresses 0..3071 once each, all data 0x2A, none while active=1. ready=1 afterwards.
- SET_Y 0x30 (value 48) → y unchanged. A PIXEL written during FILL appears after addr 3071 with its own colour.
- Assert rst mid-FILL at addr 100 → mem_we=0 the same cycle. All outputs return to reset values, and no writes occur after release.

Source files
------------

// File: rtl/arduino_pixel_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arduino_pixel_writer_if : framebuffer write-port bundle (addr/data/we)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface arduino_pixel_writer_if;
  logic [11:0] mem_addr;
  logic [5:0]  mem_data;
  logic        mem_we;

  modport master (output mem_addr, output mem_data, output mem_we);
  modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface
`default_nettype wire

// File: rtl/arduino_pixel_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arduino_pixel_writer : strobed-byte command decoder, pixel FIFO and fill |
// | engine committing framebuffer writes only during blanking.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module arduino_pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_W       = 64,
  parameter int FB_H       = 48
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              strobe_in,
  input  wire logic [7:0]        data_in,
  input  wire logic              active,
  arduino_pixel_writer_if.master fb,
  output logic                   ready,
  output logic                   overflow
);

  localparam int             c_PW    = $clog2(FIFO_DEPTH);
  localparam logic [c_PW:0]  c_PONE  = 1;
  localparam logic [11:0]    c_LAST  = 12'(FB_W * FB_H - 1);
  localparam logic [5:0]     c_XMAX  = 6'(FB_W - 1);
  localparam logic [5:0]     c_YMAX  = 6'(FB_H - 1);
  localparam logic [0:0]     c_IDLE  = 1'b0;
  localparam logic [0:0]     c_FILL  = 1'b1;

  logic        r_meta, r_sync, r_prev;
  logic        w_take, w_pix, w_setx, w_sety, w_fillcmd;
  logic [5:0]  r_x, r_y;
  logic [11:0] w_cur_addr;

  logic [17:0]   r_fifo [FIFO_DEPTH];
  logic [c_PW:0] r_wp, r_rp;
  logic          w_empty, w_full, w_push, w_pop;
  logic [17:0]   w_head;

  logic [0:0]  r_state, w_state_nx;
  logic [11:0] r_fill_addr;
  logic [5:0]  r_fill_color;
  logic        r_fill_pending;
  logic        r_overflow;
  logic        w_we;

  // Two-stage synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= strobe_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign w_take     = r_sync & ~r_prev;
  assign w_pix      = w_take & (data_in[7:6] == 2'b00);
  assign w_setx     = w_take & (data_in[7:6] == 2'b01);
  assign w_sety     = w_take & (data_in[7:6] == 2'b10);
  assign w_fillcmd  = w_take & (data_in[7:6] == 2'b11);
  assign w_cur_addr = 12'(r_y) * 12'(FB_W) + 12'(r_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= 6'd0;
      r_y <= 6'd0;
    end else if (w_pix) begin
      // Dropped pixels still advance the cursor.
      if (r_x == c_XMAX) begin
        r_x <= 6'd0;
        r_y <= (r_y == c_YMAX) ? 6'd0 : r_y + 6'd1;
      end else begin
        r_x <= r_x + 6'd1;
      end
    end else if (w_setx) begin
      r_x <= data_in[5:0];
    end else if (w_sety && (int'(data_in[5:0]) < FB_H)) begin
      r_y <= data_in[5:0];
    end
  end

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[c_PW] != r_rp[c_PW]) && (r_wp[c_PW-1:0] == r_rp[c_PW-1:0]);
  assign w_pop   = w_we & (r_state == c_IDLE);
  assign w_push  = w_pix & (~w_full | w_pop);
  assign w_head  = r_fifo[r_rp[c_PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp[c_PW-1:0]] <= {w_cur_addr, data_in[5:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + c_PONE;
      if (w_pop)  r_rp <= r_rp + c_PONE;
      if (w_pix && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nx;
  end

  // FSM: next state; a fresh FILL command on the final write keeps filling.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_IDLE:  if (r_fill_pending && w_empty) w_state_nx = c_FILL;
      c_FILL:  if (w_we && (r_fill_addr == c_LAST) && !w_fillcmd) w_state_nx = c_IDLE;
      default: w_state_nx = c_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_we        = ~active & ((r_state == c_FILL) | ~w_empty);
    fb.mem_we   = w_we;
    fb.mem_addr = 12'd0;
    fb.mem_data = 6'd0;
    if (r_state == c_FILL) begin
      fb.mem_addr = r_fill_addr;
      fb.mem_data = r_fill_color;
    end else if (!w_empty) begin
      fb.mem_addr = w_head[17:6];
      fb.mem_data = w_head[5:0];
    end
    ready    = ~w_full & ~r_fill_pending & (r_state != c_FILL);
    overflow = r_overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_addr    <= 12'd0;
      r_fill_color   <= 6'd0;
      r_fill_pending <= 1'b0;
    end else begin
      if (w_fillcmd) begin
        r_fill_color   <= data_in[5:0];
        r_fill_pending <= 1'b1;
        r_fill_addr    <= 12'd0;
      end else begin
        if (r_state == c_FILL && w_state_nx == c_IDLE) r_fill_pending <= 1'b0;
        if (r_state == c_IDLE && w_state_nx == c_FILL) r_fill_addr <= 12'd0;
        else if (r_state == c_FILL && w_we)             r_fill_addr <= r_fill_addr + 12'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arduino_pixel_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_arduino_pixel_writer : randomized bench with a cursor/queue model     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_arduino_pixel_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       active = 1'b0;
  logic       ready, overflow;

  arduino_pixel_writer_if fb ();

  arduino_pixel_writer #(.FIFO_DEPTH(4), .FB_W(64), .FB_H(48)) u_dut (
    .clk(clk), .rst(rst), .strobe_in(strobe_in), .data_in(data_in),
    .active(active), .fb(fb), .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 0: low, 1: high, 2: random 50%, 3: random 25% high
  int act_mode = 0;
  always @(posedge clk) begin
    #1;
    case (act_mode)
      0: active = 1'b0;
      1: active = 1'b1;
      2: active = ($urandom_range(0, 1) == 1);
      default: active = ($urandom_range(0, 3) == 0);
    endcase
  end

  int cycle = 0;
  always @(posedge clk) cycle++;

  int obs_addr[$], obs_data[$], obs_cyc[$];
  int act_viol = 0;
  always @(negedge clk) begin
    if (!rst && fb.mem_we) begin
      obs_addr.push_back(int'(fb.mem_addr));
      obs_data.push_back(int'(fb.mem_data));
      obs_cyc.push_back(cycle);
      if (active) act_viol++;
    end
  end

  // Reference model: cursor position and ordered list of expected pixel writes.
  int mx = 0, my = 0;
  int exp_addr[$], exp_data[$];

  task automatic model_cmd(input logic [7:0] b);
    int v;
    v = int'(b[5:0]);
    case (b[7:6])
      2'b00: begin
        exp_addr.push_back(my * 64 + mx);
        exp_data.push_back(v);
        mx++;
        if (mx == 64) begin
          mx = 0;
          my = (my + 1) % 48;
        end
      end
      2'b01: mx = v;
      2'b10: if (v < 48) my = v;
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    data_in   = b;
    strobe_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    strobe_in = 1'b0;
    repeat (3) @(posedge clk);
    model_cmd(b);
  endtask

  task automatic clear_all();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic drain_and_compare(input string tag);
    int n;
    for (int i = 0; i < 2000 && obs_addr.size() < exp_addr.size(); i++) @(posedge clk);
    repeat (10) @(posedge clk);
    check_eq({tag, "_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
      check_eq({tag, "_data"}, 32'(obs_data[i]), 32'(exp_data[i]));
    end
    clear_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"},   32'(fb.mem_we),   32'd0);
    check_eq({tag, "_addr"}, 32'(fb.mem_addr), 32'd0);
    check_eq({tag, "_data"}, 32'(fb.mem_data), 32'd0);
    check_eq({tag, "_rdy"},  32'(ready),       32'd1);
    check_eq({tag, "_ovf"},  32'(overflow),    32'd0);
  endtask

  initial begin
    int seen[3072];
    int bad, covered, found;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // Basic pixel and cursor advance
    send(8'h45); send(8'h8A); send(8'h3F);
    drain_and_compare("pix645");
    send(8'h00);
    drain_and_compare("pix646");

    // Cursor wrap at the last pixel
    send(8'h7F); send(8'hAF); send(8'h01); send(8'h02);
    drain_and_compare("wrap");

    // Overflow with video held active
    act_mode = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    @(negedge clk);
    check_eq("ovf_ready_low", 32'(ready), 32'd0);
    check_eq("ovf_we_low", 32'(fb.mem_we), 32'd0);
    send(8'h14);
    void'(exp_addr.pop_back());
    void'(exp_data.pop_back());
    @(negedge clk);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    check_eq("ovf_no_writes", 32'(obs_addr.size()), 32'd0);
    act_mode = 0;
    repeat (10) @(posedge clk);
    for (int i = 1; i < obs_cyc.size(); i++)
      check_eq("ovf_consec", 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd1);
    drain_and_compare("ovf_drain");
    @(negedge clk);
    check_eq("ovf_ready_back", 32'(ready), 32'd1);

    // Out-of-range SET_Y is ignored
    send(8'h45); send(8'h8A); send(8'hB0); send(8'h07);
    drain_and_compare("sety_ign");

    // Fill with toggling active, pixel queued mid-fill
    act_mode = 2;
    send(8'hEA);
    send(8'h43); send(8'h82); send(8'h15);
    @(negedge clk);
    check_eq("fill_ready_low", 32'(ready), 32'd0);
    for (int i = 0; i < 20000 && obs_addr.size() < 3073; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    act_mode = 0;
    check_eq("fill_count", 32'(obs_addr.size()), 32'd3073);
    bad = 0;
    covered = 0;
    for (int i = 0; i < 3072; i++) seen[i] = 0;
    for (int i = 0; i < 3072 && i < obs_addr.size(); i++) begin
      if (obs_addr[i] < 3072) seen[obs_addr[i]]++;
      if (obs_data[i] != 32'h2A) bad++;
    end
    for (int i = 0; i < 3072; i++) if (seen[i] == 1) covered++;
    check_eq("fill_data", 32'(bad), 32'd0);
    check_eq("fill_cover", 32'(covered), 32'd3072);
    if (obs_addr.size() > 3072) begin
      check_eq("fill_tail_addr", 32'(obs_addr[3072]), 32'(exp_addr[0]));
      check_eq("fill_tail_data", 32'(obs_data[3072]), 32'(exp_data[0]));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("fill_ready_after", 32'(ready), 32'd1);
    clear_all();

    // Randomized cursor/pixel traffic against the model
    act_mode = 3;
    for (int i = 0; i < 40; i++) begin
      b = {2'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
      send(b);
    end
    act_mode = 0;
    drain_and_compare("rand");
    check_eq("no_write_in_active", 32'(act_viol), 32'd0);

    // Reset in the middle of a fill
    send(8'hC5);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (fb.mem_we && fb.mem_addr == 12'd100) found = 1;
    end
    check_eq("midrst_reached", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mx = 0;
    my = 0;
    clear_all();
    repeat (100) @(posedge clk);
    check_eq("midrst_quiet", 32'(obs_addr.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
